// File: rtl/reg4_bank_write_arbiter_pkg.sv
// Shared types, default widths and decode helper for the register-bank write arbiter.
package reg4_bank_write_arbiter_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Indices at or beyond limit decode to all-zeros so out-of-range writes are dropped.
    function automatic logic [31:0] onehot(input logic [31:0] idx, input logic [31:0] limit);
        logic [31:0] vec;
        vec = '0;
        if (idx < limit) begin
            vec[idx[4:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/reg4_bank_write_arbiter_if.sv
// Requester-side and bank-side signal bundle of the register-bank write arbiter.
interface reg4_bank_write_arbiter_if
    import reg4_bank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      flush_req;
    logic                      busy;
    logic                      flush_done;
    logic [NUM_REGS-1:0]       reg_en;
    logic [DATA_W-1:0]         reg_data;
    logic [NUM_REGS-1:0]       reg_clear;

    modport master (
        output req, req_addr, req_data, flush_req,
        input  gnt, busy, flush_done, reg_en, reg_data, reg_clear
    );

    modport slave (
        input  req, req_addr, req_data, flush_req,
        output gnt, busy, flush_done, reg_en, reg_data, reg_clear
    );
endinterface

// File: rtl/reg4_bank_write_arbiter_rr_priority_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_priority_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner_onehot,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any_valid
);

    always_comb begin
        int pos;
        winner_onehot = '0;
        winner_idx    = '0;
        any_valid     = 1'b0;
        pos           = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any_valid && eligible[pos]) begin
                any_valid          = 1'b1;
                winner_idx         = PTR_W'(pos);
                winner_onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg4_bank_write_arbiter.sv
// Round-robin arbiter for the single write port of the 4-bit register bank,
// plus a one-register-per-cycle bank flush sequencer. All outputs registered.
module reg4_bank_write_arbiter
    import reg4_bank_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      clear,
    reg4_bank_write_arbiter_if.slave  bus
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [FIDX_W-1:0]   flush_idx_q, flush_idx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic [NUM_REGS-1:0] reg_clear_q, reg_clear_d;
    logic [DATA_W-1:0]   reg_data_q, reg_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [PTR_W-1:0]    win_idx;
    logic                any_valid;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [31:0]         addr_dec;
    logic [31:0]         flush_dec;

    // Masking the live grant keeps a requester that holds req past its grant from winning twice.
    assign eligible = bus.req & ~gnt_q;
    assign win_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_data = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign addr_dec = onehot(32'(win_addr), 32'(NUM_REGS));

    rr_priority_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .eligible      (eligible),
        .ptr           (rr_ptr_q),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx),
        .any_valid     (any_valid)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        flush_idx_d = flush_idx_q;
        gnt_d       = '0;
        reg_en_d    = '0;
        reg_clear_d = '0;
        reg_data_d  = reg_data_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        flush_dec   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_idx_d = '0;
                    busy_d      = 1'b1;
                    flush_dec   = onehot(32'd0, 32'(NUM_REGS));
                    reg_en_d    = flush_dec[NUM_REGS-1:0];
                    reg_clear_d = flush_dec[NUM_REGS-1:0];
                    reg_data_d  = '0;
                end else if (any_valid) begin
                    gnt_d      = win_onehot;
                    reg_en_d   = addr_dec[NUM_REGS-1:0];
                    reg_data_d = win_data;
                    rr_ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                end
            end
            ST_FLUSH: begin
                // The bank only latches on clk&enable, so reg_en must travel with reg_clear.
                if (int'(flush_idx_q) == NUM_REGS - 1) begin
                    state_d     = ST_IDLE;
                    flush_idx_d = '0;
                    done_d      = 1'b1;
                end else begin
                    flush_idx_d = flush_idx_q + 1'b1;
                    busy_d      = 1'b1;
                    flush_dec   = onehot(32'(flush_idx_d), 32'(NUM_REGS));
                    reg_en_d    = flush_dec[NUM_REGS-1:0];
                    reg_clear_d = flush_dec[NUM_REGS-1:0];
                    reg_data_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            flush_idx_q <= '0;
            gnt_q       <= '0;
            reg_en_q    <= '0;
            reg_clear_q <= '0;
            reg_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            flush_idx_q <= flush_idx_d;
            gnt_q       <= gnt_d;
            reg_en_q    <= reg_en_d;
            reg_clear_q <= reg_clear_d;
            reg_data_q  <= reg_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.reg_en     = reg_en_q;
    assign bus.reg_clear  = reg_clear_q;
    assign bus.reg_data   = reg_data_q;
    assign bus.busy       = busy_q;
    assign bus.flush_done = done_q;

endmodule
